// File: rtl/cve2_pkg.sv
// cve2_pkg: shared cve2 types used by the execute-stage units.
package cve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

endpackage

// File: rtl/cve2_multdiv_iter.sv
// cve2_multdiv_iter: iterative RV32M multiply/divide, one shift-add or restoring-divide step per cycle.
module cve2_multdiv_iter
    import cve2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mult_en_i,
    input  logic        div_en_i,
    input  md_op_e      operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        valid_o,
    output logic [31:0] multdiv_result_o
);

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_e;

    state_e      state_q, state_d;
    md_op_e      op_q;
    logic [31:0] a_q, b_q, mag_a, mag_b, quo, rem;
    logic [63:0] acc_q, acc_step, prod;
    logic [32:0] add_x, add_y, add_s;
    logic [4:0]  cnt_q;
    logic        neg_q, neg_r, mult_q, start, active_en, sign_a, sign_b;

    assign start     = mult_en_i | div_en_i;
    assign active_en = mult_q ? mult_en_i : div_en_i;
    assign sign_a    = signed_mode_i[0] & op_a_i[31];
    assign sign_b    = signed_mode_i[1] & op_b_i[31];
    assign mag_a     = sign_a ? -op_a_i : op_a_i;
    assign mag_b     = sign_b ? -op_b_i : op_b_i;

    // One 33-bit adder: multiply adds |a| into the high half, divide subtracts |b| from {rem, next dividend bit}
    assign add_x    = mult_q ? {1'b0, acc_q[63:32]} : acc_q[63:31];
    assign add_y    = mult_q ? {1'b0, b_q[0] ? a_q : 32'd0} : ~{1'b0, b_q};
    assign add_s    = add_x + add_y + {32'd0, ~mult_q};
    assign acc_step = mult_q ? {add_s, acc_q[31:1]}
                             : {add_s[32] ? acc_q[62:31] : add_s[31:0], acc_q[30:0], ~add_s[32]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? ITER : IDLE)
                : (state_q == ITER && active_en) ? (cnt_q == 5'd0 ? FINISH : ITER)
                : IDLE;
    end

    // Divide keeps {remainder, quotient/dividend} in acc_q; multiply keeps the partial product there
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mult_q <= 1'b0;
            op_q   <= MD_OP_MULL;
        end else if (state_q == IDLE && start) begin
            a_q    <= mag_a;
            b_q    <= mag_b;
            acc_q  <= mult_en_i ? 64'd0 : {32'd0, mag_a};
            cnt_q  <= 5'd31;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            mult_q <= mult_en_i;
            op_q   <= operator_i;
        end else if (state_q == ITER) begin
            acc_q <= acc_step;
            b_q   <= mult_q ? b_q >> 1 : b_q;
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = (neg_q && b_q != '0) ? -acc_q[31:0] : acc_q[31:0];
    assign rem  = neg_r ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        valid_o          = state_q == FINISH;
        multdiv_result_o = !valid_o ? 32'd0
                         : mult_q ? (op_q == MD_OP_MULL ? prod[31:0] : prod[63:32])
                         : (op_q == MD_OP_REM ? rem : quo);
    end

endmodule

// File: tb/tb_cve2_multdiv_iter.sv
// tb_cve2_multdiv_iter: directed checks of the iterative multiply/divide unit.
module tb_cve2_multdiv_iter;
    import cve2_pkg::*;

    logic        clk, rst_n, mult_en, div_en, valid;
    md_op_e      operator;
    logic [1:0]  mode;
    logic [31:0] op_a, op_b, result;
    int          checks = 0;
    int          errors = 0;
    int          pulses;

    cve2_multdiv_iter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mult_en_i       (mult_en),
        .div_en_i        (div_en),
        .operator_i      (operator),
        .signed_mode_i   (mode),
        .op_a_i          (op_a),
        .op_b_i          (op_b),
        .valid_o         (valid),
        .multdiv_result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts an op, scrambles operands during ITER, checks valid timing and the result
    task automatic do_op(input logic m, input logic d, input md_op_e op, input logic [1:0] md,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                         input string tag);
        mult_en = m; div_en = d; operator = op; mode = md; op_a = a; op_b = b;
        tick(1);
        op_a = ~a; op_b = b ^ 32'h5A5A_0F0F;
        tick(31);
        check({31'd0, valid}, 32'd0, {tag, "_valid_c32"});
        tick(1);
        check({31'd0, valid}, 32'd1, {tag, "_valid_c33"});
        check(result, exp, {tag, "_result"});
        mult_en = 1'b0; div_en = 1'b0;
        tick(1);
        check({31'd0, valid}, 32'd0, {tag, "_valid_c34"});
    endtask

    initial begin
        rst_n = 1'b0; mult_en = 1'b0; div_en = 1'b0; operator = MD_OP_MULL;
        mode = 2'b00; op_a = '0; op_b = '0;
        tick(2);
        check({31'd0, valid}, 32'd0, "reset_valid");
        check(result, 32'd0, "reset_result");
        rst_n = 1'b1;
        tick(1);

        do_op(1, 0, MD_OP_MULL, 2'b11, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        do_op(1, 0, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        do_op(1, 0, MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        do_op(1, 0, MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(0, 1, MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg7_2");
        do_op(0, 1, MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg7_2");
        do_op(0, 1, MD_OP_DIV,  2'b00, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, "divu");
        do_op(0, 1, MD_OP_DIV,  2'b11, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0");
        do_op(0, 1, MD_OP_DIV,  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_neg5_0");
        do_op(0, 1, MD_OP_REM,  2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_neg5_0");
        do_op(0, 1, MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(0, 1, MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");
        do_op(1, 1, MD_OP_MULL, 2'b00, 32'd6,         32'd9,         32'd54,        "mul_wins");

        // Abort: drop mult_en at cycle 10
        mult_en = 1'b1; operator = MD_OP_MULL; mode = 2'b00; op_a = 32'd5; op_b = 32'd5;
        tick(10);
        mult_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (valid) pulses++;
        end
        check(pulses, 32'd0, "abort_no_valid");
        do_op(1, 0, MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd12, "mul_after_abort");

        // Reset at cycle 20 with the enable still held
        div_en = 1'b1; operator = MD_OP_DIV; mode = 2'b00; op_a = 32'd100; op_b = 32'd7;
        tick(20);
        rst_n = 1'b0;
        tick(1);
        check({31'd0, valid}, 32'd0, "rst_mid_valid");
        check(result, 32'd0, "rst_mid_result");
        div_en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (valid) pulses++;
        end
        check(pulses, 32'd0, "rst_mid_no_valid");

        // Back-to-back DIVU with div_en held across both operations
        div_en = 1'b1; operator = MD_OP_DIV; mode = 2'b00; op_a = 32'd100; op_b = 32'd7;
        tick(33);
        check({31'd0, valid}, 32'd1, "b2b_valid1");
        check(result, 32'd14, "b2b_result1");
        tick(1);
        check({31'd0, valid}, 32'd0, "b2b_gap");
        tick(32);
        check({31'd0, valid}, 32'd0, "b2b_early2");
        tick(1);
        check({31'd0, valid}, 32'd1, "b2b_valid2");
        check(result, 32'd14, "b2b_result2");
        div_en = 1'b0;
        tick(1);
        check({31'd0, valid}, 32'd0, "b2b_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
